// File: rtl/ff_bank_controller.sv
// Round-robin write-path arbiter and full-bank clear sequencer for an enable/clear flip-flop register bank.
// Optional macro FF_BANK_CTRL_STATS_EN adds a saturating 16-bit accept_count output.
module ff_bank_controller #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_clear,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic                       clear_all,
  output logic [NUM_REGS-1:0]        ff_enable,
  output logic [NUM_REGS-1:0]        ff_reset,
  output logic [DATA_W-1:0]          ff_data,
  output logic [ID_W-1:0]            grant_id,
  output logic                       busy,
  output logic                       done,
`ifdef FF_BANK_CTRL_STATS_EN
  output logic [15:0]                accept_count,
`endif
  output logic                       addr_err
);

  // state | meaning
  // IDLE  | arbitrating requesters; clear_all starts a sweep
  // SWEEP | walking ff_reset across the bank, requesters stalled
  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [ADDR_W:0]   REGS_LIM = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS-1);
  localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(NUM_REQ-1);

  state_t              state;
  logic [ID_W-1:0]     rr;
  logic [ID_W-1:0]     win;
  logic                win_found;
  logic                accept;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic                win_clear;
  logic [ADDR_W-1:0]   sweep_left;

  // Two passes give the rotating priority rr, rr+1, ... without a modulo index.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && i >= int'(rr) && req_valid[i]) begin
        win_found = 1'b1;
        win       = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && i < int'(rr) && req_valid[i]) begin
        win_found = 1'b1;
        win       = ID_W'(i);
      end
    end
  end

  always_comb begin
    win_addr  = '0;
    win_data  = '0;
    win_clear = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) begin
        win_addr  = req_addr[i*ADDR_W +: ADDR_W];
        win_data  = req_data[i*DATA_W +: DATA_W];
        win_clear = req_clear[i];
      end
    end
  end

  assign accept    = (state == IDLE) && !clear_all && win_found;
  assign req_ready = accept ? (NUM_REQ'(1) << win) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr         <= '0;
      sweep_left <= '0;
      ff_enable  <= '0;
      ff_reset   <= '0;
      ff_data    <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      ff_enable <= '0;
      ff_reset  <= '0;
      ff_data   <= '0;
      done      <= 1'b0;
      addr_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_all) begin
            state      <= SWEEP;
            sweep_left <= LAST_IDX;
            busy       <= 1'b1;
            ff_reset   <= NUM_REGS'(1);
          end else if (accept) begin
            rr       <= (win == LAST_ID) ? '0 : win + 1'b1;
            grant_id <= win;
            // Out-of-range ops are consumed so the requester is not stuck retrying.
            if ({1'b0, win_addr} >= REGS_LIM) begin
              addr_err <= 1'b1;
            end else if (win_clear) begin
              ff_reset <= NUM_REGS'(1) << win_addr;
            end else begin
              ff_enable <= NUM_REGS'(1) << win_addr;
              ff_data   <= win_data;
            end
          end
        end
        SWEEP: begin
          if (sweep_left == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            sweep_left <= sweep_left - 1'b1;
            ff_reset   <= ff_reset << 1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FF_BANK_CTRL_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      accept_count <= '0;
    end else if (accept && accept_count != 16'hFFFF) begin
      accept_count <= accept_count + 16'd1;
    end
  end
`endif

endmodule
